// File: rtl/key_search_table.sv
// Key/data table with a sequential reverse lookup: given a data value, scan entries
// one per cycle from index 0 and report the key and index of the first valid match.
module key_search_table #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(NR_KEY)-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]         wr_key,
    input  logic [DATA_LEN-1:0]        wr_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_LEN-1:0]        req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_hit,
    output logic [KEY_LEN-1:0]         resp_key,
    output logic [$clog2(NR_KEY)-1:0]  resp_idx
);
    localparam int IDX_LEN = $clog2(NR_KEY);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t state, state_nxt;

    logic [NR_KEY-1:0]   ent_valid;
    logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
    logic [DATA_LEN-1:0] ent_data [NR_KEY];

    logic [DATA_LEN-1:0] search_data;
    logic [IDX_LEN-1:0]  scan_idx;
    logic                hit_q;
    logic [KEY_LEN-1:0]  key_q;
    logic [IDX_LEN-1:0]  idx_q;
    logic                match, last;

    // Compare against registered contents, so a write this cycle is seen next cycle.
    assign match = ent_valid[scan_idx] && (ent_data[scan_idx] == search_data);
    assign last  = (scan_idx == IDX_LEN'(NR_KEY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SCAN;
            end
            SCAN: if (match || last) state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_key[wr_idx]  <= wr_key;
            ent_data[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid   <= '0;
            search_data <= '0;
            scan_idx    <= '0;
            hit_q       <= 1'b0;
            key_q       <= '0;
            idx_q       <= '0;
        end else begin
            if (wr_en) ent_valid[wr_idx] <= 1'b1;
            case (state)
                IDLE: if (req_valid) begin
                    search_data <= req_data;
                    scan_idx    <= '0;
                end
                SCAN: begin
                    if (match) begin
                        hit_q <= 1'b1;
                        key_q <= ent_key[scan_idx];
                        idx_q <= scan_idx;
                    end else if (last) begin
                        hit_q <= 1'b0;
                        key_q <= '0;
                        idx_q <= '0;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_hit = hit_q;
    assign resp_key = key_q;
    assign resp_idx = idx_q;
endmodule

// File: doc/key_search_table.md
KEY_SEARCH_TABLE -- requirements
Module: key_search_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 8, number of table entries; power of two, at least 2.
REQ-002 SHALL have parameter KEY_LEN, default 4, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 8, data width in bits.
REQ-004 SHALL define IDX_LEN = $clog2(NR_KEY) as a local parameter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port wr_en  input  1  table write strobe.
REQ-008 SHALL have port wr_idx  input  IDX_LEN  entry index to write.
REQ-009 SHALL have port wr_key  input  KEY_LEN  key stored at wr_idx.
REQ-010 SHALL have port wr_data  input  DATA_LEN  data stored at wr_idx.
REQ-011 SHALL have port req_valid  input  1  search request valid.
REQ-012 SHALL have port req_ready  output  1  search request accepted when high with req_valid.
REQ-013 SHALL have port req_data  input  DATA_LEN  data value to reverse-look-up.
REQ-014 SHALL have port resp_valid  output  1  search result valid.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-016 SHALL have port resp_hit  output  1  a matching entry was found.
REQ-017 SHALL have port resp_key  output  KEY_LEN  key of the matching entry; 0 on miss.
REQ-018 SHALL have port resp_idx  output  IDX_LEN  index of the matching entry; 0 on miss.

Function
REQ-019 SHALL hold NR_KEY entries, each {valid, key, data}; only entries with valid=1 take part in a search.
REQ-020 SHALL, on a clock edge with wr_en=1, store wr_key/wr_data at wr_idx and set its valid bit, in any FSM state; the new contents are visible from the next cycle.
REQ-021 SHALL implement FSM states IDLE, SCAN, RESP.
REQ-022 SHALL drive req_ready=1 only in IDLE and resp_valid=1 only in RESP.
REQ-023 SHALL, in IDLE with req_valid=1, latch req_data, clear the scan index to 0 and go to SCAN.
REQ-024 SHALL, in SCAN, compare exactly one entry per cycle, at the current scan index, against the latched data, using the registered table contents of that cycle.
REQ-025 SHALL, on the first match, register hit=1, that entry's key and its index, then go to RESP; the lowest matching index wins.
REQ-026 SHALL, when entry NR_KEY-1 does not match, register hit=0, key=0 and idx=0, then go to RESP; the scan index SHALL NOT wrap.
REQ-027 SHALL give a latency, for a request accepted in cycle T with a match at index i, of resp_valid high from cycle T+2+i; a miss SHALL give resp_valid high from T+1+NR_KEY.
REQ-028 SHALL hold resp_hit, resp_key and resp_idx stable while resp_valid=1 and resp_ready=0.
REQ-029 SHALL, in RESP with resp_ready=1, return to IDLE the next cycle; a new request SHALL NOT be accepted in that same cycle.
REQ-030 SHALL, when a write hits an entry that the scan has not yet reached, use the new value for that entry; an entry already passed SHALL NOT be re-examined.

Reset
REQ-031 SHALL, while rst=1, asynchronously set the FSM to IDLE and clear all valid bits, the scan index and the result registers.
REQ-032 SHALL drive req_ready=1, resp_valid=0, resp_hit=0, resp_key=0 and resp_idx=0 during and after reset.
REQ-033 SHALL, when rst is asserted mid-SCAN or in RESP, abandon the search and produce no response for it.

Verification
REQ-034 SHALL be tested with an empty table after reset, searching 0x00: resp_valid at T+9 with hit=0, key=0, idx=0.
REQ-035 SHALL be tested by writing idx3={key 0xA, data 0x5C}, then searching 0x5C accepted at T: resp_valid at T+5 with hit=1, key=0xA, idx=3.
REQ-036 SHALL be tested with duplicates idx2={0x1,0x77} and idx6={0x2,0x77}, searching 0x77: hit=1, key=0x1, idx=2.
REQ-037 SHALL be tested with resp_ready held 0 for 5 cycles in RESP: outputs stable, req_ready=0, and a single response completes on release.
REQ-038 SHALL be tested by writing idx7={0xF,0x99} during SCAN at index 2, searching 0x99: hit=1, key=0xF, idx=7.
REQ-039 SHALL be tested by asserting rst in SCAN: resp_valid never asserts, req_ready=1 after reset, and a re-search of a previously written value misses.
